// File: rtl/multi_dac_output_path.sv
// Four-channel, two-chip I2S DAC output path.
// FIFO fetch into a sample buffer, serialized on shared BCK/LRCK.
module multi_dac_output_path #(
  parameter int dac_channels   = 4,
  parameter int bck_half       = 2,
  parameter int slots_per_half = 32
) (
  input  logic        capture_clk,
  input  logic        rst_n,
  input  logic        dac_fifo_open_bus,
  input  logic [31:0] dac_fifo_data,
  input  logic        dac_empty,
  output logic        dac_rden,
  output logic        dac_open,
  output logic        dac_underrun,
  output logic        DAC_BCK,
  output logic [0:1]  DAC_DATA_PINS,
  output logic        DAC_LRCK,
  output logic        DAC_NOT_RST
);

  localparam int DIVW = (bck_half > 1) ? $clog2(bck_half) : 1;
  localparam int SLW  = $clog2(slots_per_half);
  localparam int IW   = $clog2(dac_channels + 1);
  localparam int BW   = dac_channels * 32;

  typedef enum logic {
    F_IDLE,
    F_READ
  } fstate_t;

  logic            open_meta;
  logic [BW-1:0]   dac_buffer;
  logic            dac_request;
  logic            running;
  logic [DIVW-1:0] div_cnt;
  logic [SLW-1:0]  slot;
  logic [47:0]     sh0;
  logic [47:0]     sh1;
  logic [47:0]     load0;
  logic [47:0]     load1;

  fstate_t         fstate;
  fstate_t         fstate_nx;
  logic [IW-1:0]   rd_idx;
  logic [IW-1:0]   rd_idx_nx;
  logic            set_underrun;
  logic            rden_q;
  logic [1:0]      cap_idx;

  logic            unused_low;

  assign unused_low = ^{dac_buffer[7:0], dac_buffer[39:32],
                        dac_buffer[71:64], dac_buffer[103:96]};

  // Chip 0 carries words 0/1, chip 1 words 2/3; low byte dropped
  assign load0 = {dac_buffer[31:8], dac_buffer[63:40]};
  assign load1 = {dac_buffer[95:72], dac_buffer[127:104]};

  always_ff @(posedge capture_clk or negedge rst_n) begin
    if (!rst_n) begin
      open_meta   <= 1'b0;
      dac_open    <= 1'b0;
      DAC_NOT_RST <= 1'b0;
    end else begin
      open_meta   <= dac_fifo_open_bus;
      dac_open    <= open_meta;
      DAC_NOT_RST <= dac_open;
    end
  end

  always_ff @(posedge capture_clk or negedge rst_n) begin
    if (!rst_n) begin
      running       <= 1'b0;
      div_cnt       <= '0;
      slot          <= '0;
      DAC_BCK       <= 1'b0;
      DAC_LRCK      <= 1'b0;
      DAC_DATA_PINS <= '0;
      sh0           <= '0;
      sh1           <= '0;
      dac_request   <= 1'b0;
    end else if (!dac_open) begin
      running       <= 1'b0;
      div_cnt       <= '0;
      slot          <= '0;
      DAC_BCK       <= 1'b0;
      DAC_LRCK      <= 1'b0;
      DAC_DATA_PINS <= '0;
      dac_request   <= 1'b0;
    end else begin
      dac_request <= 1'b0;
      if (!running) begin
        running     <= 1'b1;
        div_cnt     <= '0;
        sh0         <= load0;
        sh1         <= load1;
        dac_request <= 1'b1;
      end else if (div_cnt == DIVW'(bck_half - 1)) begin
        div_cnt <= '0;
        DAC_BCK <= ~DAC_BCK;
        // Everything visible to the DAC moves on the BCK falling edge
        if (DAC_BCK) begin
          if (slot == SLW'(slots_per_half - 1)) begin
            slot          <= '0;
            DAC_LRCK      <= ~DAC_LRCK;
            DAC_DATA_PINS <= '0;
            if (DAC_LRCK) begin
              sh0         <= load0;
              sh1         <= load1;
              dac_request <= 1'b1;
            end
          end else begin
            slot <= slot + 1'b1;
            if (slot < SLW'(24)) begin
              DAC_DATA_PINS <= {sh0[47], sh1[47]};
              sh0           <= {sh0[46:0], 1'b0};
              sh1           <= {sh1[46:0], 1'b0};
            end else begin
              DAC_DATA_PINS <= '0;
            end
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    fstate_nx    = fstate;
    rd_idx_nx    = rd_idx;
    dac_rden     = 1'b0;
    set_underrun = 1'b0;
    unique case (fstate)
      F_IDLE: begin
        if (dac_request && dac_open) begin
          fstate_nx = F_READ;
          rd_idx_nx = '0;
        end
      end
      F_READ: begin
        if (!dac_open) begin
          fstate_nx = F_IDLE;
        end else if (rd_idx == IW'(dac_channels)) begin
          fstate_nx = F_IDLE;
        end else if (dac_empty) begin
          set_underrun = 1'b1;
          fstate_nx    = F_IDLE;
        end else begin
          dac_rden  = 1'b1;
          rd_idx_nx = rd_idx + 1'b1;
        end
      end
      default: fstate_nx = F_IDLE;
    endcase
  end

  always_ff @(posedge capture_clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate <= F_IDLE;
      rd_idx <= '0;
    end else begin
      fstate <= fstate_nx;
      rd_idx <= rd_idx_nx;
    end
  end

  // Read data lands one cycle after rden
  always_ff @(posedge capture_clk or negedge rst_n) begin
    if (!rst_n) begin
      rden_q     <= 1'b0;
      cap_idx    <= '0;
      dac_buffer <= '0;
    end else begin
      rden_q  <= dac_rden;
      cap_idx <= rd_idx[1:0];
      if (rden_q) begin
        dac_buffer[{cap_idx, 5'd0} +: 32] <= dac_fifo_data;
      end
    end
  end

  always_ff @(posedge capture_clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_underrun <= 1'b0;
    end else if (!dac_open) begin
      dac_underrun <= 1'b0;
    end else if (set_underrun) begin
      dac_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_dac_output_path.sv
// Directed bench for multi_dac_output_path.
// FIFO model plus I2S receiver; frames compared to hand values.
module tb_multi_dac_output_path;

  logic        capture_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dac_fifo_open_bus = 1'b0;
  logic [31:0] dac_fifo_data = '0;
  logic        dac_empty = 1'b1;
  logic        dac_rden;
  logic        dac_open;
  logic        dac_underrun;
  logic        DAC_BCK;
  logic [0:1]  DAC_DATA_PINS;
  logic        DAC_LRCK;
  logic        DAC_NOT_RST;

  int checks = 0;
  int errors = 0;

  typedef logic [3:0][23:0] samp_t;
  typedef struct {
    logic [3:0][31:0] w;
    samp_t            e;
  } vec_t;

  multi_dac_output_path dut (
    .capture_clk      (capture_clk),
    .rst_n            (rst_n),
    .dac_fifo_open_bus(dac_fifo_open_bus),
    .dac_fifo_data    (dac_fifo_data),
    .dac_empty        (dac_empty),
    .dac_rden         (dac_rden),
    .dac_open         (dac_open),
    .dac_underrun     (dac_underrun),
    .DAC_BCK          (DAC_BCK),
    .DAC_DATA_PINS    (DAC_DATA_PINS),
    .DAC_LRCK         (DAC_LRCK),
    .DAC_NOT_RST      (DAC_NOT_RST)
  );

  always #5 capture_clk = ~capture_clk;

  logic [31:0] fifo_q[$];
  int          rden_cnt = 0;
  int          bad_pop = 0;

  always @(posedge capture_clk) begin
    if (dac_rden) begin
      rden_cnt++;
      if (fifo_q.size() == 0) bad_pop++;
      else dac_fifo_data <= fifo_q.pop_front();
    end
    dac_empty <= (fifo_q.size() == 0);
  end

  samp_t       rx_q[$];
  logic [23:0] acc0, acc1, l0, l1;
  int          slot_m;
  bit          got_left;
  bit          first_seen;
  logic        prev_bck;
  logic        prev_lr;
  int          pad_err = 0;
  int          lr_err = 0;

  always @(negedge capture_clk) begin
    if (!rst_n || !dac_open) begin
      prev_bck   = 1'b0;
      prev_lr    = 1'b1;
      slot_m     = 0;
      got_left   = 1'b0;
      first_seen = 1'b0;
    end else begin
      if (DAC_BCK && !prev_bck) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          if (DAC_LRCK !== 1'b0) lr_err++;
        end
        if (DAC_LRCK != prev_lr) slot_m = 0;
        else slot_m++;
        if (slot_m >= 1 && slot_m <= 24) begin
          acc0 = {acc0[22:0], DAC_DATA_PINS[0]};
          acc1 = {acc1[22:0], DAC_DATA_PINS[1]};
        end else if (DAC_DATA_PINS !== 2'b00) begin
          pad_err++;
        end
        if (slot_m == 24) begin
          if (!DAC_LRCK) begin
            l0 = acc0;
            l1 = acc1;
            got_left = 1'b1;
          end else if (got_left) begin
            samp_t s;
            s[0] = l0;
            s[1] = acc0;
            s[2] = l1;
            s[3] = acc1;
            rx_q.push_back(s);
            got_left = 1'b0;
          end
        end
        prev_lr = DAC_LRCK;
      end
      prev_bck = DAC_BCK;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (rx_q.size() < n && t < 3000) begin
      @(negedge capture_clk);
      t++;
    end
    chk("frame_wait", 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic chk_frame(input string name, input samp_t exp);
    samp_t got;
    got = '0;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    for (int i = 0; i < 4; i++) chk(name, 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic push_vec(input vec_t v);
    for (int i = 0; i < 4; i++) fifo_q.push_back(v.w[i]);
  endtask

  task automatic wait_rise(output int cyc);
    int t = 0;
    logic p;
    p = DAC_BCK;
    cyc = 0;
    while (t < 200) begin
      @(negedge capture_clk);
      t++;
      if (DAC_BCK && !p) begin
        cyc = t;
        break;
      end
      p = DAC_BCK;
    end
  endtask

  function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3,
                              input logic [23:0] e0, e1, e2, e3);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    return v;
  endfunction

  initial begin
    vec_t  tbl[4];
    vec_t  va;
    vec_t  vb;
    samp_t zero_s;
    samp_t mix_s;
    int    c;
    int    base;
    int    per;
    int    t;

    tbl[0] = mk(32'h0A1B0C1D, 32'h1A1B1C1D, 32'h2A1B2C1D, 32'h3A1B3C1D,
                24'h0A1B0C, 24'h1A1B1C, 24'h2A1B2C, 24'h3A1B3C);
    tbl[1] = mk(32'h000001FF, 32'h800000AA, 32'hFFFFFF00, 32'h12345678,
                24'h000001, 24'h800000, 24'hFFFFFF, 24'h123456);
    tbl[2] = mk(32'h00000200, 32'h7FFFFF11, 32'h55AA55CC, 32'h00000000,
                24'h000002, 24'h7FFFFF, 24'h55AA55, 24'h000000);
    tbl[3] = mk(32'h00000300, 32'hC3C3C3C3, 32'h01020304, 32'hAAAAAAAA,
                24'h000003, 24'hC3C3C3, 24'h010203, 24'hAAAAAA);
    va = mk(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
            24'h112233, 24'h556677, 24'h99AABB, 24'hDDEEFF);
    vb = mk(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0, 32'h0,
            24'h0F0F0F, 24'hF0F0F0, 24'h0, 24'h0);
    zero_s = '0;
    mix_s[0] = 24'h0F0F0F;
    mix_s[1] = 24'hF0F0F0;
    mix_s[2] = 24'h99AABB;
    mix_s[3] = 24'hDDEEFF;

    repeat (3) @(negedge capture_clk);
    chk("rst_rden", 32'(dac_rden), 0);
    chk("rst_open", 32'(dac_open), 0);
    chk("rst_underrun", 32'(dac_underrun), 0);
    chk("rst_bck", 32'(DAC_BCK), 0);
    chk("rst_lrck", 32'(DAC_LRCK), 0);
    chk("rst_pins", 32'(DAC_DATA_PINS), 0);
    chk("rst_nrst", 32'(DAC_NOT_RST), 0);

    rst_n = 1'b1;
    fifo_q.push_back(32'hDEADBEEF);
    repeat (20) @(negedge capture_clk);
    chk("closed_bck", 32'(DAC_BCK), 0);
    chk("closed_lrck", 32'(DAC_LRCK), 0);
    chk("closed_rden", 32'(rden_cnt), 0);
    fifo_q.delete();
    repeat (2) @(negedge capture_clk);

    dac_fifo_open_bus = 1'b1;
    c = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge capture_clk);
      if (DAC_NOT_RST) begin
        c = i;
        break;
      end
    end
    chk("nrst_latency", 32'(c), 3);
    repeat (10) @(negedge capture_clk);
    chk("underrun_first", 32'(dac_underrun), 1);
    for (int i = 0; i < 4; i++) push_vec(tbl[i]);

    wait_rise(c);
    wait_rise(per);
    chk("bck_period", 32'(per), 4);

    wait_frames(6);
    chk_frame("frame0_zero", zero_s);
    chk_frame("frame1_zero", zero_s);
    for (int i = 0; i < 4; i++) chk_frame($sformatf("vec%0d", i), tbl[i].e);
    chk("rden_total", 32'(rden_cnt), 16);
    chk("underrun_sticky", 32'(dac_underrun), 1);

    t = 0;
    while (DAC_LRCK && t < 400) begin @(negedge capture_clk); t++; end
    while (!DAC_LRCK && t < 400) begin @(negedge capture_clk); t++; end
    per = 0;
    while (DAC_LRCK && t < 800) begin @(negedge capture_clk); t++; per++; end
    while (!DAC_LRCK && t < 800) begin @(negedge capture_clk); t++; per++; end
    chk("frame_len", 32'(per), 256);

    dac_fifo_open_bus = 1'b0;
    repeat (5) @(negedge capture_clk);
    chk("close_bck", 32'(DAC_BCK), 0);
    chk("close_lrck", 32'(DAC_LRCK), 0);
    chk("close_pins", 32'(DAC_DATA_PINS), 0);
    chk("close_nrst", 32'(DAC_NOT_RST), 0);
    chk("close_underrun", 32'(dac_underrun), 0);

    push_vec(va);
    base = rden_cnt;
    repeat (2) @(negedge capture_clk);
    rx_q.delete();
    dac_fifo_open_bus = 1'b1;
    repeat (20) @(negedge capture_clk);
    chk("reopen_rden", 32'(rden_cnt - base), 4);
    chk("reopen_underrun", 32'(dac_underrun), 0);
    fifo_q.push_back(vb.w[0]);
    fifo_q.push_back(vb.w[1]);

    wait_frames(3);
    chk_frame("reopen_f0", tbl[3].e);
    chk_frame("reopen_f1", va.e);
    chk_frame("partial_f2", mix_s);
    chk("partial_underrun", 32'(dac_underrun), 1);
    chk("partial_rden", 32'(rden_cnt - base), 6);
    chk("pad_bits", 32'(pad_err), 0);
    chk("first_lrck", 32'(lr_err), 0);
    chk("bad_pop", 32'(bad_pop), 0);

    repeat (37) @(negedge capture_clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_bck", 32'(DAC_BCK), 0);
    chk("midrst_lrck", 32'(DAC_LRCK), 0);
    chk("midrst_pins", 32'(DAC_DATA_PINS), 0);
    chk("midrst_nrst", 32'(DAC_NOT_RST), 0);
    chk("midrst_open", 32'(dac_open), 0);
    chk("midrst_underrun", 32'(dac_underrun), 0);
    dac_fifo_open_bus = 1'b0;
    fifo_q.push_back(32'h12345678);
    base = rden_cnt;
    @(negedge capture_clk);
    rst_n = 1'b1;
    repeat (30) @(negedge capture_clk);
    chk("post_rst_bck", 32'(DAC_BCK), 0);
    chk("post_rst_lrck", 32'(DAC_LRCK), 0);
    chk("post_rst_rden", 32'(rden_cnt - base), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
